// File: rtl/pwl_pkg.sv
// rtl/pwl_pkg.sv - shared types, GELU default segment table and saturation helper for the PWL activation unit
package pwl_pkg;

    localparam int PWL_DATA_W  = 8;
    localparam int PWL_NUM_SEG = 4;
    localparam int PWL_SH_W    = 3;

    typedef enum logic [1:0] {
        KIND_CONST = 2'd0,
        KIND_ADD   = 2'd1,
        KIND_SUB   = 2'd2,
        KIND_IDENT = 2'd3
    } kind_e;

    typedef struct packed {
        logic signed [PWL_DATA_W-1:0] bp;
        kind_e                        kind;
        logic        [PWL_SH_W-1:0]   sh;
        logic signed [PWL_DATA_W-1:0] off;
    } seg_t;

    // Q3.5 GELU approximation; the last breakpoint is never compared
    localparam seg_t GELU_TABLE [PWL_NUM_SEG] = '{
        '{bp: -8'sd80, kind: KIND_CONST, sh: 3'd0, off:  8'sd0},
        '{bp: -8'sd16, kind: KIND_SUB,   sh: 3'd4, off: -8'sd1},
        '{bp:  8'sd0,  kind: KIND_ADD,   sh: 3'd2, off: -8'sd5},
        '{bp:  8'sd0,  kind: KIND_IDENT, sh: 3'd0, off:  8'sd0}
    };

    function automatic seg_t gelu_default(input int idx);
        seg_t s;
        s = '{bp: '0, kind: KIND_IDENT, sh: '0, off: '0};
        if (idx < PWL_NUM_SEG) begin
            s = GELU_TABLE[idx];
        end
        return s;
    endfunction

    function automatic int pwl_saturate(input int r, input int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (r > hi) begin
            return hi;
        end
        if (r < lo) begin
            return lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/pwl_seg_eval.sv
// rtl/pwl_seg_eval.sv - combinational second-stage datapath: shift, add/sub against offset, saturate
module pwl_seg_eval
    import pwl_pkg::*;
#(
    parameter int DATA_W = PWL_DATA_W,
    parameter int SH_W   = PWL_SH_W
) (
    input  logic signed [DATA_W:0]   d_i,
    input  kind_e                    kind_i,
    input  logic        [SH_W-1:0]   sh_i,
    input  logic signed [DATA_W-1:0] off_i,
    input  logic signed [DATA_W-1:0] x_i,
    output logic signed [DATA_W-1:0] y_o,
    output logic                     sat_o
);

    logic signed [DATA_W:0]   t;
    logic signed [DATA_W+1:0] off_x;
    logic signed [DATA_W+1:0] t_x;
    logic signed [DATA_W+1:0] r;
    int                       r_int;
    int                       s_int;

    assign t     = d_i >>> sh_i;
    assign off_x = {{2{off_i[DATA_W-1]}}, off_i};
    assign t_x   = {t[DATA_W], t};

    always_comb begin
        r = off_x;
        case (kind_i)
            KIND_CONST: r = off_x;
            KIND_ADD:   r = off_x + t_x;
            KIND_SUB:   r = off_x - t_x;
            KIND_IDENT: r = {{2{x_i[DATA_W-1]}}, x_i};
            default:    r = off_x;
        endcase
        r_int = int'(r);
        s_int = pwl_saturate(r_int, DATA_W);
        y_o   = DATA_W'(s_int);
        sat_o = (s_int != r_int);
    end

endmodule

// File: rtl/pwl_act_pipe.sv
// rtl/pwl_act_pipe.sv - two-stage piecewise-linear activation with programmable segment table and stream handshake
module pwl_act_pipe
    import pwl_pkg::*;
#(
    parameter int DATA_W  = PWL_DATA_W,
    parameter int NUM_SEG = PWL_NUM_SEG,
    parameter int SH_W    = PWL_SH_W,
    parameter int IDX_W   = $clog2(NUM_SEG)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] y_out,
    output logic                     sat_flag,
    input  logic                     cfg_we,
    input  logic        [IDX_W-1:0]  cfg_idx,
    input  logic signed [DATA_W-1:0] cfg_bp,
    input  logic        [1:0]        cfg_kind,
    input  logic        [SH_W-1:0]   cfg_sh,
    input  logic signed [DATA_W-1:0] cfg_off
);

    localparam logic signed [DATA_W-1:0] SAMPLE_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W-1:0] bp_q   [NUM_SEG];
    kind_e                    kind_q [NUM_SEG];
    logic        [SH_W-1:0]   sh_q   [NUM_SEG];
    logic signed [DATA_W-1:0] off_q  [NUM_SEG];
    seg_t                     seg_dflt [NUM_SEG];

    logic                     run_q;
    logic                     s1_valid_q, s1_valid_d;
    logic signed [DATA_W:0]   s1_d_q, s1_d_d;
    kind_e                    s1_kind_q;
    logic        [SH_W-1:0]   s1_sh_q;
    logic signed [DATA_W-1:0] s1_off_q;
    logic signed [DATA_W-1:0] s1_x_q;
    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] y_q;
    logic                     sat_q;

    logic                     s2_load;
    logic                     accept;
    logic        [IDX_W-1:0]  sel_idx;
    logic signed [DATA_W-1:0] sel_base;
    logic signed [DATA_W-1:0] eval_y;
    logic                     eval_sat;
    logic                     idx_ok;

    always_comb begin
        for (int i = 0; i < NUM_SEG; i++) begin
            seg_dflt[i] = gelu_default(i);
        end
    end

    // Descending scan so the lowest matching segment wins, even for a non-ascending table
    always_comb begin
        sel_idx  = IDX_W'(NUM_SEG - 1);
        sel_base = bp_q[NUM_SEG-2];
        for (int i = NUM_SEG - 2; i >= 1; i--) begin
            if (x_in < bp_q[i]) begin
                sel_idx  = IDX_W'(i);
                sel_base = bp_q[i-1];
            end
        end
        if (x_in < bp_q[0]) begin
            sel_idx  = '0;
            sel_base = SAMPLE_MIN;
        end
        s1_d_d = {x_in[DATA_W-1], x_in} - {sel_base[DATA_W-1], sel_base};
    end

    assign s2_load     = ~out_valid_q | out_ready;
    assign in_ready    = run_q & (~s1_valid_q | s2_load) & ~cfg_we;
    assign accept      = in_valid & in_ready;
    assign s1_valid_d  = accept | (s1_valid_q & ~s2_load);
    assign out_valid_d = s2_load ? s1_valid_q : out_valid_q;
    assign idx_ok      = ({1'b0, cfg_idx} < (IDX_W+1)'(NUM_SEG));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SEG; i++) begin
                bp_q[i]   <= DATA_W'(seg_dflt[i].bp);
                kind_q[i] <= seg_dflt[i].kind;
                sh_q[i]   <= SH_W'(seg_dflt[i].sh);
                off_q[i]  <= DATA_W'(seg_dflt[i].off);
            end
        end else if (cfg_we && idx_ok) begin
            bp_q[cfg_idx]   <= cfg_bp;
            kind_q[cfg_idx] <= kind_e'(cfg_kind);
            sh_q[cfg_idx]   <= cfg_sh;
            off_q[cfg_idx]  <= cfg_off;
        end
    end

    // S1 captures the segment parameters so a later table write cannot affect it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_d_q     <= '0;
            s1_kind_q  <= KIND_CONST;
            s1_sh_q    <= '0;
            s1_off_q   <= '0;
            s1_x_q     <= '0;
        end else begin
            run_q      <= 1'b1;
            s1_valid_q <= s1_valid_d;
            if (accept) begin
                s1_d_q    <= s1_d_d;
                s1_kind_q <= kind_q[sel_idx];
                s1_sh_q   <= sh_q[sel_idx];
                s1_off_q  <= off_q[sel_idx];
                s1_x_q    <= x_in;
            end
        end
    end

    pwl_seg_eval #(
        .DATA_W (DATA_W),
        .SH_W   (SH_W)
    ) u_eval (
        .d_i    (s1_d_q),
        .kind_i (s1_kind_q),
        .sh_i   (s1_sh_q),
        .off_i  (s1_off_q),
        .x_i    (s1_x_q),
        .y_o    (eval_y),
        .sat_o  (eval_sat)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            sat_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (s2_load && s1_valid_q) begin
                y_q   <= eval_y;
                sat_q <= eval_sat;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign y_out     = y_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_pwl_act_pipe.sv
// tb/tb_pwl_act_pipe.sv - directed self-checking bench for pwl_act_pipe
module tb_pwl_act_pipe;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] x_in;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] y_out;
    logic              sat_flag;
    logic              cfg_we;
    logic        [1:0] cfg_idx;
    logic signed [7:0] cfg_bp;
    logic        [1:0] cfg_kind;
    logic        [2:0] cfg_sh;
    logic signed [7:0] cfg_off;

    int n_cmp  = 0;
    int n_fail = 0;
    int vec_x [16];
    int vec_y [16];
    int vec_s [16];

    always #5 clk = ~clk;

    pwl_act_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out),
        .sat_flag  (sat_flag),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_bp    (cfg_bp),
        .cfg_kind  (cfg_kind),
        .cfg_sh    (cfg_sh),
        .cfg_off   (cfg_off)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_vec(input int i, input int x, input int y, input int s);
        vec_x[i] = x;
        vec_y[i] = y;
        vec_s[i] = s;
    endtask

    // Back-to-back stream with out_ready=1: output k appears two negedges after it was driven
    task automatic run_seq(input int n, input string tag);
        for (int k = 0; k < n + 2; k++) begin
            @(negedge clk);
            in_valid = (k < n);
            x_in     = (k < n) ? 8'(vec_x[k]) : 8'sd0;
            #1;
            if (k < n) check({tag, "_in_ready"}, in_ready, 1);
            if (k >= 2) begin
                check({tag, "_out_valid"}, out_valid, 1);
                check({tag, "_y"}, y_out, vec_y[k-2]);
                check({tag, "_sat"}, sat_flag, vec_s[k-2]);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check({tag, "_drain"}, out_valid, 0);
    endtask

    initial begin
        int sent;
        int recv;
        int cyc;
        logic last_stall;

        reset = 1'b1; in_valid = 1'b0; x_in = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_idx = '0; cfg_bp = '0; cfg_kind = '0; cfg_sh = '0; cfg_off = '0;
        #1 reset = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y_out, 0);
        check("rst_sat", sat_flag, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rdy_before_edge", in_ready, 0);

        set_vec(0, -96, 0, 0);
        set_vec(1, -48, -3, 0);
        set_vec(2, -8, -3, 0);
        set_vec(3, 40, 40, 0);
        run_seq(4, "dflt");

        set_vec(0, -80, -1, 0);
        set_vec(1, -16, -5, 0);
        set_vec(2, -1, -2, 0);
        set_vec(3, 0, 0, 0);
        set_vec(4, -128, 0, 0);
        set_vec(5, 127, 127, 0);
        run_seq(6, "bound");

        set_vec(0, -96, 0, 0);
        set_vec(1, -48, -3, 0);
        set_vec(2, -8, -3, 0);
        set_vec(3, 40, 40, 0);
        set_vec(4, -80, -1, 0);
        set_vec(5, -16, -5, 0);
        set_vec(6, -1, -2, 0);
        set_vec(7, 127, 127, 0);
        sent = 0; recv = 0; cyc = 0; last_stall = 1'b0;
        while (recv < 8 && cyc < 60) begin
            @(negedge clk);
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            in_valid  = (sent < 8);
            x_in      = (sent < 8) ? 8'(vec_x[sent]) : 8'sd0;
            #1;
            check("bp_in_ready", in_ready, !((sent - recv) == 2 && !out_ready));
            if (last_stall) check("bp_hold_valid", out_valid, 1);
            if (out_valid) check("bp_y", y_out, vec_y[recv]);
            last_stall = out_valid && !out_ready;
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) recv++;
            cyc++;
        end
        check("bp_count", recv, 8);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_drain", out_valid, 0);

        @(negedge clk);
        in_valid = 1'b1; x_in = 8'sd40;
        #1;
        check("cfg_pre_ready", in_ready, 1);
        @(negedge clk);
        x_in = 8'sd100;
        cfg_we = 1'b1; cfg_idx = 2'd3; cfg_bp = 8'sd0; cfg_kind = 2'd1; cfg_sh = 3'd0; cfg_off = 8'sd100;
        #1;
        check("cfg_blocks_in", in_ready, 0);
        @(negedge clk);
        cfg_we = 1'b0;
        #1;
        check("cfg_post_ready", in_ready, 1);
        check("cfg_inflight_valid", out_valid, 1);
        check("cfg_inflight_y", y_out, 40);
        check("cfg_inflight_sat", sat_flag, 0);
        @(negedge clk);
        x_in = 8'sd10;
        #1;
        check("cfg_no_dup", out_valid, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("cfg_sat_valid", out_valid, 1);
        check("cfg_sat_y", y_out, 127);
        check("cfg_sat_flag", sat_flag, 1);
        @(negedge clk);
        #1;
        check("cfg_add_y", y_out, 110);
        check("cfg_add_sat", sat_flag, 0);

        @(negedge clk);
        in_valid = 1'b1; x_in = -8'sd48;
        @(negedge clk);
        x_in = -8'sd8;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("mid_inflight", out_valid, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_y", y_out, 0);
        check("mid_rst_ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b1; out_ready = 1'b1;
        set_vec(0, -48, -3, 0);
        set_vec(1, 40, 40, 0);
        run_seq(2, "restored");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
